// File: rtl/imu_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : imu_spi_sequencer
//  Description : ISM330DHCX SPI master. Configures the accel/gyro, then bursts
//                six output words per sample tick as tagged signed samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module imu_spi_sequencer #(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [7:0] CTRL1_XL_VAL  = 8'h60,
    parameter logic [7:0] CTRL2_G_VAL   = 8'h60,
    parameter logic [6:0] START_ADDR    = 7'h22,
    parameter int         NUM_WORDS     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        spi_mosi,
    output logic [15:0] sample_data,
    output logic [2:0]  sample_axis,
    output logic        sample_valid,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);

    localparam int c_rd_bits = 8 + 16 * NUM_WORDS;
    localparam int c_ph_w    = $clog2(2 * c_rd_bits + 2);
    localparam int c_cnt_w   = $clog2(2 * CLK_DIV);
    localparam int c_tick_w  = $clog2(SAMPLE_PERIOD);

    // Phase 0 is CS setup, odd phases SCK low, even phases SCK high, last is hold.
    localparam logic [c_ph_w-1:0]   c_ph_last_cfg = c_ph_w'(2 * 16 + 1);
    localparam logic [c_ph_w-1:0]   c_ph_last_rd  = c_ph_w'(2 * c_rd_bits + 1);
    localparam logic [c_ph_w-1:0]   c_ph_data     = c_ph_w'(18);
    localparam logic [c_cnt_w-1:0]  c_div_last    = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_gap_last    = c_cnt_w'(2 * CLK_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_last   = c_tick_w'(SAMPLE_PERIOD - 1);
    localparam logic [2:0]          c_axis_last   = 3'(NUM_WORDS - 1);

    localparam logic [2:0] c_st_cfg1 = 3'd0;
    localparam logic [2:0] c_st_cfg2 = 3'd1;
    localparam logic [2:0] c_st_gap  = 3'd2;
    localparam logic [2:0] c_st_idle = 3'd3;
    localparam logic [2:0] c_st_read = 3'd4;

    logic [2:0]          r_state, w_state, r_gap_ret, w_gap_ret, w_tgt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt;
    logic [c_ph_w-1:0]   r_phase, w_phase, w_p, w_ph_last;
    logic [c_tick_w-1:0] r_tick_cnt, w_tick_cnt;
    logic                r_cs, w_cs, r_sck, w_sck, r_mosi, w_mosi;
    logic [15:0]         r_tx, w_tx, r_rx, w_rx, r_data, w_data;
    logic [3:0]          r_rxn, w_rxn;
    logic [2:0]          r_word, w_word, r_axis, w_axis;
    logic                r_valid, w_valid, r_frame, w_frame;
    logic                r_busy, w_busy, r_overrun, w_overrun;
    logic                w_tick, w_start;

    always_comb begin
        w_state    = r_state;
        w_gap_ret  = r_gap_ret;
        w_cnt      = r_cnt;
        w_phase    = r_phase;
        w_cs       = r_cs;
        w_sck      = r_sck;
        w_mosi     = r_mosi;
        w_tx       = r_tx;
        w_rx       = r_rx;
        w_rxn      = r_rxn;
        w_word     = r_word;
        w_data     = r_data;
        w_axis     = r_axis;
        w_valid    = 1'b0;
        w_frame    = 1'b0;
        w_start    = 1'b0;
        w_tgt      = r_state;
        w_tick     = (r_tick_cnt == c_tick_last);
        w_tick_cnt = w_tick ? '0 : r_tick_cnt + 1'b1;
        w_overrun  = w_tick && (r_state != c_st_idle);
        w_ph_last  = (r_state == c_st_read) ? c_ph_last_rd : c_ph_last_cfg;
        w_p        = r_phase + 1'b1;

        case (r_state)
            c_st_idle: begin
                if (w_tick && enable) begin
                    w_start = 1'b1;
                    w_tgt   = c_st_read;
                end
            end
            c_st_gap: begin
                if (r_cnt == c_gap_last) begin
                    w_state = r_gap_ret;
                    if (r_gap_ret != c_st_idle) begin
                        w_start = 1'b1;
                        w_tgt   = r_gap_ret;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_st_cfg1, c_st_cfg2, c_st_read: begin
                // CS still high here only on the first cycle out of reset.
                if (r_cs) begin
                    w_start = 1'b1;
                    w_tgt   = r_state;
                end else if (r_cnt != c_div_last) begin
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_cnt = '0;
                    if (r_phase == w_ph_last) begin
                        w_cs      = 1'b1;
                        w_mosi    = 1'b0;
                        w_phase   = '0;
                        w_state   = c_st_gap;
                        w_gap_ret = (r_state == c_st_cfg1) ? c_st_cfg2 : c_st_idle;
                    end else begin
                        w_phase = w_p;
                        if (w_p != w_ph_last) begin
                            if (w_p[0]) begin
                                w_sck  = 1'b0;
                                w_mosi = r_tx[15];
                                w_tx   = {r_tx[14:0], 1'b0};
                            end else begin
                                w_sck = 1'b1;
                                if ((r_state == c_st_read) && (w_p >= c_ph_data)) begin
                                    w_rx  = {r_rx[14:0], spi_miso};
                                    w_rxn = r_rxn + 1'b1;
                                    if (r_rxn == 4'd15) begin
                                        w_valid = 1'b1;
                                        w_data  = {w_rx[7:0], w_rx[15:8]};
                                        w_axis  = r_word;
                                        w_word  = r_word + 1'b1;
                                        w_frame = (r_word == c_axis_last);
                                    end
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                w_state = c_st_cfg1;
                w_cs    = 1'b1;
                w_sck   = 1'b1;
                w_mosi  = 1'b0;
            end
        endcase

        if (w_start) begin
            w_state = w_tgt;
            w_cs    = 1'b0;
            w_sck   = 1'b1;
            w_mosi  = 1'b0;
            w_cnt   = '0;
            w_phase = '0;
            w_rxn   = '0;
            case (w_tgt)
                c_st_cfg1: w_tx = {1'b0, 7'h10, CTRL1_XL_VAL};
                c_st_cfg2: w_tx = {1'b0, 7'h11, CTRL2_G_VAL};
                default:   w_tx = {1'b1, START_ADDR, 8'h00};
            endcase
            if (w_tgt == c_st_read) begin
                w_word = '0;
                w_axis = '0;
            end
        end

        w_busy = (w_state != c_st_idle) || !w_cs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_cfg1;
            r_gap_ret  <= c_st_cfg2;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_tick_cnt <= '0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b1;
            r_mosi     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rxn      <= '0;
            r_word     <= '0;
            r_data     <= '0;
            r_axis     <= '0;
            r_valid    <= 1'b0;
            r_frame    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_gap_ret  <= w_gap_ret;
            r_cnt      <= w_cnt;
            r_phase    <= w_phase;
            r_tick_cnt <= w_tick_cnt;
            r_cs       <= w_cs;
            r_sck      <= w_sck;
            r_mosi     <= w_mosi;
            r_tx       <= w_tx;
            r_rx       <= w_rx;
            r_rxn      <= w_rxn;
            r_word     <= w_word;
            r_data     <= w_data;
            r_axis     <= w_axis;
            r_valid    <= w_valid;
            r_frame    <= w_frame;
            r_busy     <= w_busy;
            r_overrun  <= w_overrun;
        end
    end

    assign spi_sck      = r_sck;
    assign spi_cs       = r_cs;
    assign spi_mosi     = r_mosi;
    assign sample_data  = r_data;
    assign sample_axis  = r_axis;
    assign sample_valid = r_valid;
    assign frame_done   = r_frame;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_imu_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imu_spi_sequencer
//  Description : Scoreboard bench with an ISM330DHCX slave model for
//                imu_spi_sequencer (SAMPLE_PERIOD shortened to 500).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imu_spi_sequencer;

    localparam int c_period = 500;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_sck, spi_cs, spi_mosi;
    logic [15:0] sample_data;
    logic [2:0]  sample_axis;
    logic        sample_valid, frame_done, busy, overrun;

    imu_spi_sequencer #(.SAMPLE_PERIOD(c_period)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spi_miso     (spi_miso),
        .spi_sck      (spi_sck),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .sample_data  (sample_data),
        .sample_axis  (sample_axis),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] exp_q[$];
    logic [7:0]  slave_bytes [12];
    logic [15:0] exp1 [6] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B};
    logic [15:0] exp2 [6] = '{16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'h8001, 16'hAA55};
    logic [15:0] tx_word [16];
    int          tx_len [16];
    int          gap_before [16];
    int          ntx = 0, ncs_fall = 0, n_strobes = 0, ov_cnt = 0;
    int          low_cnt = 0, gap_cnt = 0, bitcnt = 0, m_k = 0;
    logic [15:0] mosi_sh = '0;
    logic [19:0] m_e;
    logic        prev_sck = 1'b1, prev_cs = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sel_cnt(input int which);
        case (which)
            0:       return ntx;
            1:       return ncs_fall;
            default: return n_strobes;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int budget, input string name);
        int k;
        k = 0;
        while (sel_cnt(which) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(sel_cnt(which) >= target), 1);
    endtask

    // Slave model, framing monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (prev_cs && !spi_cs) begin
            if (ncs_fall < 16) gap_before[ncs_fall] = gap_cnt;
            ncs_fall++;
            bitcnt  = 0;
            mosi_sh = '0;
            low_cnt = 0;
        end
        if (!prev_cs && spi_cs) begin
            if (ntx < 16) begin
                tx_word[ntx] = mosi_sh;
                tx_len[ntx]  = low_cnt;
            end
            ntx++;
            gap_cnt = 0;
        end
        if (spi_cs) gap_cnt++;
        else low_cnt++;

        if (!spi_cs && prev_sck && !spi_sck) begin
            m_k = bitcnt;
            if (m_k >= 8 && m_k < 104) spi_miso = slave_bytes[(m_k - 8) / 8][7 - ((m_k - 8) % 8)];
            else spi_miso = 1'b0;
        end
        if (!spi_cs && !prev_sck && spi_sck) begin
            if (bitcnt < 16) mosi_sh = {mosi_sh[14:0], spi_mosi};
            bitcnt++;
        end

        if (sample_valid) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_unexpected: got axis %0d data 0x%h, required no strobe",
                         sample_axis, sample_data);
            end else begin
                m_e = exp_q.pop_front();
                check("sample_data", sample_data, m_e[15:0]);
                check("sample_axis", sample_axis, m_e[18:16]);
                check("frame_done", frame_done, m_e[19]);
            end
        end
        if (frame_done && !sample_valid) check("frame_without_valid", sample_valid, 1);
        if (overrun) ov_cnt++;
        prev_sck = spi_sck;
        prev_cs  = spi_cs;
    end

    initial begin
        slave_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                        8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        repeat (5) @(negedge clk);
        check("rst_cs", spi_cs, 1);
        check("rst_sck", spi_sck, 1);
        check("rst_mosi", spi_mosi, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_frame", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", sample_data, 0);
        check("rst_axis", sample_axis, 0);
        rst = 1'b0;

        // Configuration writes
        wait_cnt(0, 2, 600, "cfg_done_timeout");
        check("cfg1_word", tx_word[0], 16'h1060);
        check("cfg2_word", tx_word[1], 16'h1160);
        check("cfg1_cs_len", tx_len[0], 136);
        check("cfg_gap_ge8", 32'(gap_before[1] >= 8), 1);
        repeat (20) @(negedge clk);
        check("idle_busy", busy, 0);

        // First tick arrives with enable low
        repeat (400) @(negedge clk);
        check("gated_no_cs", ntx, 2);
        check("gated_no_overrun", ov_cnt, 0);

        // Burst 1: counting bytes, one overrun tick lands mid-burst
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 3'(i), exp1[i]});
        enable = 1'b1;
        wait_cnt(1, 3, 800, "burst1_start_timeout");
        repeat (10) @(negedge clk);
        check("burst_busy", busy, 1);
        wait_cnt(0, 3, 1000, "burst1_end_timeout");
        check("burst1_cs_len", tx_len[2], 840);
        check("burst1_addr", tx_word[2], 16'hA200);
        check("burst1_strobes", n_strobes, 6);
        check("burst1_queue_empty", exp_q.size(), 0);
        check("burst1_overrun", ov_cnt, 1);
        repeat (100) @(negedge clk);
        check("no_burst_for_dropped_tick", ntx, 3);

        // Burst 2: sign patterns, enable dropped mid-burst
        slave_bytes = '{8'h00, 8'h80, 8'hFF, 8'hFF, 8'h34, 8'h12,
                        8'hFF, 8'h7F, 8'h01, 8'h80, 8'h55, 8'hAA};
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 3'(i), exp2[i]});
        wait_cnt(1, 4, 400, "burst2_start_timeout");
        repeat (200) @(negedge clk);
        enable = 1'b0;
        wait_cnt(0, 4, 1000, "burst2_end_timeout");
        check("burst2_strobes", n_strobes, 12);
        check("burst2_queue_empty", exp_q.size(), 0);
        check("burst2_overrun", ov_cnt, 2);
        repeat (1300) @(negedge clk);
        check("disabled_no_burst", ntx, 4);
        check("disabled_no_overrun", ov_cnt, 2);

        // Burst 3: reset after the third word
        slave_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                        8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 3'(i), exp1[i]});
        enable = 1'b1;
        wait_cnt(2, 15, 1500, "burst3_words_timeout");
        check("midrst_cs_low_before", spi_cs, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", spi_cs, 1);
        check("midrst_sck", spi_sck, 1);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        enable = 1'b0;
        wait_cnt(0, 7, 600, "recfg_timeout");
        check("recfg1_word", tx_word[5], 16'h1060);
        check("recfg2_word", tx_word[6], 16'h1160);
        repeat (50) @(negedge clk);
        check("midrst_no_more_strobes", n_strobes, 15);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/imu_spi_sequencer.md
# imu_spi_sequencer

SPI master and read scheduler for the ISM330DHCX IMU in the system clock domain. After reset it writes the accelerometer and gyroscope control registers. It then issues a periodic burst read of the six output words (gyro X/Y/Z, accel X/Y/Z) and presents each word as a signed big-endian sample with an axis tag to the Kalman filter front end. It generates `spi_sck`, `spi_cs` and `spi_mosi` itself and deserializes MISO internally, so downstream logic sees only tagged parallel samples.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period, ≥2.
- `SAMPLE_PERIOD`, 1000: `clk` cycles between sample ticks, greater than one burst length.
- `CTRL1_XL_VAL`, 8'h60: byte written to register 0x10.
- `CTRL2_G_VAL`, 8'h60: byte written to register 0x11.
- `START_ADDR`, 7'h22: first burst register (OUTX_L_G).
- `NUM_WORDS`, 6: 16-bit words per burst.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: permits new bursts.
- `spi_miso` in 1: sensor SDO.
- `spi_sck` out 1: SPI clock, mode 3, idles high.
- `spi_cs` out 1: chip select, active low.
- `spi_mosi` out 1: sensor SDI.
- `sample_data` out 16: signed word, {high byte, low byte}.
- `sample_axis` out 3: word index 0..NUM_WORDS-1 in burst order.
- `sample_valid` out 1: one-cycle strobe qualifying data/axis.
- `frame_done` out 1: one-cycle strobe after the last word of a burst.
- `busy` out 1: high whenever `spi_cs` is low or the FSM is not in IDLE.
- `overrun` out 1: one-cycle strobe when a sample tick is dropped.

## Operation
- FSM states: CFG1 → GAP → CFG2 → GAP → IDLE ↔ (READ → GAP).
  - CFG1 and CFG2 send a 16-bit write: {0, addr[6:0], data}, with 0x10/CTRL1_XL_VAL then 0x11/CTRL2_G_VAL.
  - READ sends {1, START_ADDR} and then clocks 16×NUM_WORDS bits with MOSI=0. The sensor auto-increments.
  - GAP holds CS high for 2×CLK_DIV cycles, then moves to the next state.
- Tick counter runs free from reset. It pulses every SAMPLE_PERIOD cycles.
  - In IDLE with `enable`=1, a tick starts READ.
  - A tick while the FSM is not in IDLE raises `overrun` for one cycle and the tick is dropped. This includes ticks during configuration.
  - A tick with `enable`=0 in IDLE is ignored, with no overrun.
- Dropping `enable` mid-burst does not abort the burst.
- Bytes arrive MSB first. Within each word the first byte is the low byte.
  - Output word = {second byte, first byte}, passed through unmodified as a two's-complement value.
- `sample_axis` resets to 0 at each burst start and increments after each strobe.

## Timing
- Transaction framing:
  - `spi_cs` falls at state entry, with SCK high for CLK_DIV setup cycles.
  - Each bit is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
  - After the last bit, SCK stays high for CLK_DIV hold cycles, then CS rises.
- `spi_mosi` changes only on the `clk` edge that drives SCK low. It is 0 when CS is high.
- `spi_miso` is sampled on the `clk` edge that drives SCK low→high.
- `sample_valid` rises on the cycle after the 16th bit of a word is sampled, lasts one cycle, and data/axis hold until the next strobe.
  - `frame_done` coincides with the last word's `sample_valid`.
- Burst length from CS fall to CS rise = 2×CLK_DIV + (8+16×NUM_WORDS)×2×CLK_DIV. With defaults this is 840 cycles.
- Reset values:
  - `spi_cs`=1, `spi_sck`=1, `spi_mosi`=0.
  - `sample_data`=0, `sample_axis`=0.
  - All strobes and `busy`=0.
  - FSM=CFG1 and tick counter=0.
  - CFG1 begins on the first cycle after `rst` is released.
- Reset asserted mid-transaction: on the next edge CS goes high and SCK goes high. The partial word is discarded with no strobe, and configuration reruns.

## Test plan
- Reset with defaults:
  - During `rst`: CS=1, SCK=1, all strobes 0.
  - After release: MOSI bits decode as 0x10,0x60, then CS is high for ≥8 cycles, then 0x11,0x60, then IDLE with `busy`=0.
- Burst read: a slave model returns bytes 0x01..0x0C after address 0xA2.
  - Required: six strobes with data 0x0201, 0x0403, 0x0605, 0x0807, 0x0A09, 0x0C0B and axis 0..5.
  - `frame_done` coincides with axis 5.
  - CS low for exactly 840 cycles.
- Sign pass-through: the slave returns 0x00,0x80 for word 0.
  - Required: `sample_data`=0x8000 with no extension artifacts. 0xFF,0xFF gives 0xFFFF.
- Overrun: SAMPLE_PERIOD=500.
  - Required: the first burst completes intact.
  - A tick during the burst produces an `overrun` pulse and no second burst until the next tick in IDLE.
- Enable gating: `enable`=0 at the tick gives no CS activity and no overrun.
  - Deasserting `enable` mid-burst still yields all six samples.
- Mid-burst reset: `rst` after 3 words gives CS=1 and SCK=1 the next cycle, no further strobes, and the configuration writes repeat.
